// File: rtl/uart_pkg.sv
// Shared UART definitions for the 6809 terminal path.
// Contents: receive deframer state encoding, default bit period, and the bit
// positions of the status byte that uart_interface assembles from this
// block's flags.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_RECOVER = 3'd4
  } rx_state_t;

  // 88.67 MHz oscillator / 115200 baud, rounded
  localparam int DEFAULT_CLKS_PER_BIT = 770;

  // Status byte bit positions
  localparam int STAT_RX_NOT_EMPTY = 0;
  localparam int STAT_OVERRUN      = 1;
  localparam int STAT_FRAMING_ERR  = 2;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word fall-through FIFO.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   i_push, i_data     write request and data
//   i_pop              remove head entry (ignored when empty)
//   o_data             head entry, read straight from the register array
//   o_count            entries held, 0..DEPTH
//   o_full, o_empty    derived from o_count
//   o_drop             one-cycle pulse: push refused because full and no pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_drop
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CNW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CNW-1:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  assign w_full    = (r_count == CNW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      // Cleared so the head reads 0x00 after reset.
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_drop  = i_push && !w_do_push;

endmodule

// File: rtl/uart_rx_buffer.sv
// UART 8N1 receive front end with receive queue.
// Oversamples the FT2232 line on clk, deframes characters and queues them.
// Ports:
//   clk, reset        oscillator clock, synchronous active-high reset
//   i_rx_serial       asynchronous serial input, idle high
//   i_pop             single-cycle strobe removing the head byte
//   i_clear_err       single-cycle strobe clearing both sticky flags
//   o_rx_data         head byte (fall-through), valid while !o_empty
//   o_empty/o_full    queue state; o_count bytes held
//   o_overrun         sticky: completed byte dropped on a full queue
//   o_framing_err     sticky: stop bit sampled low
//   o_irq             high while the queue holds data
//
// state   | meaning
// IDLE    | line idle, waiting for a low on the synchronized line
// START   | timing to mid start bit to reject glitches
// DATA    | sampling 8 data bits, LSB first, one per bit period
// STOP    | sampling the stop bit, push on high
// RECOVER | bad stop bit seen, waiting for the line to return high
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_rx_serial,
  input  logic                          i_pop,
  output logic [7:0]                    o_rx_data,
  output logic                          o_empty,
  output logic                          o_full,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_overrun,
  output logic                          o_framing_err,
  input  logic                          i_clear_err,
  output logic                          o_irq
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LP_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LP_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    r_sync;
  logic          w_rx;
  rx_state_t     r_state;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_push;
  logic          r_framing_err;
  logic          r_overrun;
  logic          w_empty;
  logic          w_drop;

  always_ff @(posedge clk) begin
    if (reset) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], i_rx_serial};
  end

  assign w_rx = r_sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_clk_cnt     <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_push        <= 1'b0;
      r_framing_err <= 1'b0;
    end else begin
      r_push <= 1'b0;
      // Placed before the FSM so a same-cycle framing error overrides it.
      if (i_clear_err) r_framing_err <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_bit_idx <= '0;
          if (!w_rx) begin
            r_clk_cnt <= '0;
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          if (r_clk_cnt == LP_HALF_LAST) begin
            r_clk_cnt <= '0;
            r_state   <= w_rx ? ST_IDLE : ST_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_clk_cnt == LP_BIT_LAST) begin
            r_clk_cnt <= '0;
            r_shift   <= {w_rx, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) r_state <= ST_STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (r_clk_cnt == LP_BIT_LAST) begin
            r_clk_cnt <= '0;
            if (w_rx) begin
              r_push  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_framing_err <= 1'b1;
              r_state       <= ST_RECOVER;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        ST_RECOVER: begin
          // Holding here through a break keeps it from producing 0x00 bytes.
          if (w_rx) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_push),
    .i_data  (r_shift),
    .i_pop   (i_pop),
    .o_data  (o_rx_data),
    .o_count (o_count),
    .o_full  (o_full),
    .o_empty (w_empty),
    .o_drop  (w_drop)
  );

  always_ff @(posedge clk) begin
    if (reset)            r_overrun <= 1'b0;
    else if (w_drop)      r_overrun <= 1'b1;
    else if (i_clear_err) r_overrun <= 1'b0;
  end

  assign o_empty       = w_empty;
  assign o_irq         = !w_empty;
  assign o_overrun     = r_overrun;
  assign o_framing_err = r_framing_err;

endmodule

// File: tb/tb_uart_rx_buffer.sv
module tb_uart_rx_buffer;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic       i_rx_serial;
  logic       i_pop;
  logic       i_clear_err;
  logic [7:0] o_rx_data;
  logic       o_empty;
  logic       o_full;
  logic [2:0] o_count;
  logic       o_overrun;
  logic       o_framing_err;
  logic       o_irq;

  int tests_run;
  int tests_failed;
  int lat;

  uart_rx_buffer #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_rx_serial   (i_rx_serial),
    .i_pop         (i_pop),
    .o_rx_data     (o_rx_data),
    .o_empty       (o_empty),
    .o_full        (o_full),
    .o_count       (o_count),
    .o_overrun     (o_overrun),
    .o_framing_err (o_framing_err),
    .i_clear_err   (i_clear_err),
    .o_irq         (o_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Serialize one frame, one iteration per clock. pop_at / clr_at raise the
  // strobe so it is seen on edge (value+1) counted from the start-bit edge;
  // abort_at stops driving mid-frame. latency = edges until o_empty falls.
  task automatic send_frame(input logic [7:0] data, input logic stop_val,
                            input int pop_at, input int clr_at,
                            input int abort_at, output int latency);
    logic [9:0] bits;
    logic       prev_empty;
    bits    = {stop_val, data, 1'b0};
    latency = -1;
    for (int c = 0; c < 10 * CPB; c++) begin
      if (c == abort_at) begin
        i_pop = 1'b0;
        i_clear_err = 1'b0;
        return;
      end
      i_rx_serial = bits[c / CPB];
      i_pop       = (c == pop_at);
      i_clear_err = (c == clr_at);
      prev_empty  = o_empty;
      @(posedge clk);
      #1;
      if (latency < 0 && prev_empty && !o_empty) latency = c + 1;
    end
    i_pop       = 1'b0;
    i_clear_err = 1'b0;
    i_rx_serial = 1'b1;
  endtask

  task automatic pop_one();
    i_pop = 1'b1;
    tick(1);
    i_pop = 1'b0;
  endtask

  task automatic clear_err();
    i_clear_err = 1'b1;
    tick(1);
    i_clear_err = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    i_rx_serial = 1'b1;
    i_pop       = 1'b0;
    i_clear_err = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
    tests_run++;
    if ({o_empty, o_full, o_irq, o_overrun, o_framing_err} !== 5'b10000) begin
      tests_failed++;
      $display("FAIL reset_flags: got e/f/irq/ov/fe=%b expected 10000",
               {o_empty, o_full, o_irq, o_overrun, o_framing_err});
    end
    tests_run++;
    if (o_count !== 3'd0 || o_rx_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_data: got count=%0d data=%h expected 0 00", o_count, o_rx_data);
    end
  endtask

  task automatic test_single();
    send_frame(8'hA5, 1'b1, -1, -1, -1, lat);
    tests_run++;
    if (lat < 154 || lat > 158) begin
      tests_failed++;
      $display("FAIL single_latency: got %0d clocks expected 154..158", lat);
    end
    tests_run++;
    if (o_rx_data !== 8'hA5 || o_count !== 3'd1 || o_irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_data: got data=%h count=%0d irq=%b expected a5 1 1",
               o_rx_data, o_count, o_irq);
    end
    pop_one();
    tests_run++;
    if (o_empty !== 1'b1 || o_count !== 3'd0 || o_irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_pop: got empty=%b count=%0d irq=%b expected 1 0 0",
               o_empty, o_count, o_irq);
    end
  endtask

  task automatic test_glitch();
    i_rx_serial = 1'b0;
    tick(5);
    i_rx_serial = 1'b1;
    tick(40);
    tests_run++;
    if (o_count !== 3'd0 || o_overrun !== 1'b0 || o_framing_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch: got count=%0d ov=%b fe=%b expected 0 0 0",
               o_count, o_overrun, o_framing_err);
    end
    pop_one();
    tick(1);
    tests_run++;
    if (o_count !== 3'd0 || o_empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL pop_empty: got count=%0d empty=%b expected 0 1", o_count, o_empty);
    end
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1'b0, -1, -1, -1, lat);
    i_rx_serial = 1'b0;
    tick(40);
    tests_run++;
    if (o_framing_err !== 1'b1 || o_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL framing_set: got fe=%b count=%0d expected 1 0", o_framing_err, o_count);
    end
    i_rx_serial = 1'b1;
    tick(5);
    send_frame(8'h55, 1'b1, -1, -1, -1, lat);
    tests_run++;
    if (o_rx_data !== 8'h55 || o_count !== 3'd1) begin
      tests_failed++;
      $display("FAIL framing_next: got data=%h count=%0d expected 55 1", o_rx_data, o_count);
    end
    pop_one();
    clear_err();
    tests_run++;
    if (o_framing_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL framing_clear: got fe=%b expected 0", o_framing_err);
    end
    // Clear strobe coincides with the bad stop-bit sample: flag must end set.
    send_frame(8'h00, 1'b0, -1, 154, -1, lat);
    tick(5);
    tests_run++;
    if (o_framing_err !== 1'b1 || o_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL framing_set_wins: got fe=%b count=%0d expected 1 0", o_framing_err, o_count);
    end
    clear_err();
  endtask

  task automatic test_overrun_wrap();
    for (int b = 1; b <= 5; b++) begin
      send_frame(8'(b), 1'b1, -1, -1, -1, lat);
      if (b == 4) begin
        tests_run++;
        if (o_full !== 1'b1 || o_overrun !== 1'b0) begin
          tests_failed++;
          $display("FAIL full_at_4: got full=%b ov=%b expected 1 0", o_full, o_overrun);
        end
      end
    end
    tests_run++;
    if (o_overrun !== 1'b1 || o_count !== 3'd4) begin
      tests_failed++;
      $display("FAIL overrun: got ov=%b count=%0d expected 1 4", o_overrun, o_count);
    end
    for (int b = 1; b <= 4; b++) begin
      tests_run++;
      if (o_rx_data !== 8'(b)) begin
        tests_failed++;
        $display("FAIL overrun_read: got %h expected %h", o_rx_data, 8'(b));
      end
      pop_one();
    end
    tests_run++;
    if (o_empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_drained: got empty=%b expected 1", o_empty);
    end
    clear_err();
    tests_run++;
    if (o_overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL overrun_clear: got ov=%b expected 0", o_overrun);
    end
    send_frame(8'h06, 1'b1, -1, -1, -1, lat);
    send_frame(8'h07, 1'b1, -1, -1, -1, lat);
    tests_run++;
    if (o_count !== 3'd2 || o_rx_data !== 8'h06) begin
      tests_failed++;
      $display("FAIL wrap_06: got count=%0d data=%h expected 2 06", o_count, o_rx_data);
    end
    pop_one();
    tests_run++;
    if (o_rx_data !== 8'h07) begin
      tests_failed++;
      $display("FAIL wrap_07: got %h expected 07", o_rx_data);
    end
    pop_one();
  endtask

  task automatic test_push_pop_full();
    logic [7:0] exp_q [4];
    exp_q = '{8'h21, 8'h22, 8'h23, 8'h09};
    for (int b = 0; b < 4; b++) send_frame(8'h20 + 8'(b), 1'b1, -1, -1, -1, lat);
    tests_run++;
    if (o_full !== 1'b1 || o_rx_data !== 8'h20) begin
      tests_failed++;
      $display("FAIL pp_fill: got full=%b data=%h expected 1 20", o_full, o_rx_data);
    end
    // Pop lands on the write edge of 0x09.
    send_frame(8'h09, 1'b1, 155, -1, -1, lat);
    tests_run++;
    if (o_count !== 3'd4 || o_overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL pp_same_cycle: got count=%0d ov=%b expected 4 0", o_count, o_overrun);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (o_rx_data !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL pp_read: got %h expected %h", o_rx_data, exp_q[i]);
      end
      pop_one();
    end
  endtask

  task automatic test_reset_mid();
    send_frame(8'h33, 1'b1, -1, -1, -1, lat);
    send_frame(8'h99, 1'b1, -1, -1, 88, lat);
    reset = 1'b1;
    tick(2);
    reset       = 1'b0;
    i_rx_serial = 1'b1;
    tests_run++;
    if ({o_empty, o_full, o_irq, o_overrun, o_framing_err} !== 5'b10000 ||
        o_count !== 3'd0 || o_rx_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_mid: got flags=%b count=%0d data=%h expected 10000 0 00",
               {o_empty, o_full, o_irq, o_overrun, o_framing_err}, o_count, o_rx_data);
    end
    tick(200);
    tests_run++;
    if (o_count !== 3'd0 || o_framing_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_partial: got count=%0d fe=%b expected 0 0", o_count, o_framing_err);
    end
    send_frame(8'h7E, 1'b1, -1, -1, -1, lat);
    tests_run++;
    if (o_rx_data !== 8'h7E || o_count !== 3'd1) begin
      tests_failed++;
      $display("FAIL reset_mid_next: got data=%h count=%0d expected 7e 1", o_rx_data, o_count);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_single();
    test_glitch();
    test_framing();
    test_overrun_wrap();
    test_push_pop_full();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
